mux_gate_sequencer: RTL and testbench

Round-robin controller that shares one bit-serial, mux-based logic gate between several requesters. Each requester submits a two-operand bitwise op (OR/AND/XOR/XNOR). The sequencer arbitrates, latches the operands, and steps the single 1-bit mux-gate datapath across the word, one bit per cycle. It then returns the result with the winner's ID. It sits between the mux-gate primitive and the blocks that need bitwise logic without their own gate array.

---
 rtl/mux_gate_pkg.sv | 15 +
 rtl/mux_gate_unit.sv | 29 ++
 rtl/mux_gate_sequencer.sv | 142 ++++++++++++++
 tb/tb_mux_gate_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_gate_pkg.sv
// rtl/mux_gate_pkg.sv - shared op codes and FSM states for the mux-gate sequencer
package mux_gate_pkg;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_gate_unit.sv
// rtl/mux_gate_unit.sv - one-bit logic gate built from a single 2:1 mux
module mux_gate_unit
  import mux_gate_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);

  logic i0;
  logic i1;

  // a drives the mux select; op only chooses what is presented on each leg
  always_comb begin
    i0 = b;
    i1 = 1'b1;
    case (op)
      OP_OR:   begin i0 = b;    i1 = 1'b1; end
      OP_AND:  begin i0 = 1'b0; i1 = b;    end
      OP_XOR:  begin i0 = b;    i1 = ~b;   end
      OP_XNOR: begin i0 = ~b;   i1 = b;    end
      default: begin i0 = b;    i1 = 1'b1; end
    endcase
  end

  assign y = a ? i1 : i0;

endmodule

// File: rtl/mux_gate_sequencer.sv
// rtl/mux_gate_sequencer.sv - round-robin sharing of one bit-serial mux gate
// Optional op_count statistics output enabled by MUX_GATE_SEQ_STATS_EN.
module mux_gate_sequencer
  import mux_gate_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [2*N_REQ-1:0]         op_flat,
  input  logic [N_REQ*WIDTH-1:0]     a_flat,
  input  logic [N_REQ*WIDTH-1:0]     b_flat,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [WIDTH-1:0]           y
`ifdef MUX_GATE_SEQ_STATS_EN
  ,
  output logic [15:0]                op_count
`endif
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int KW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   sel_id;
  logic [KW-1:0]     k;
  logic              k_last;
  logic [1:0]        op_lat;
  logic [WIDTH-1:0]  a_lat;
  logic [WIDTH-1:0]  b_lat;
  logic [WIDTH-1:0]  res;
  logic [WIDTH-1:0]  res_nxt;
  logic              gate_y;
  logic              found;
  int                idx;

  assign k_last = (k == KW'(WIDTH - 1));

  // first set request at or after rr_ptr, wrapping
  always_comb begin
    sel_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        sel_id = idx[ID_W-1:0];
      end
    end
  end

  mux_gate_unit u_gate (
    .a  (a_lat[k]),
    .b  (b_lat[k]),
    .op (op_lat),
    .y  (gate_y)
  );

  always_comb begin
    res_nxt    = res;
    res_nxt[k] = gate_y;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_EVAL;
      S_EVAL:  if (k_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    if (state == S_EVAL && k == '0) grant[cur_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      cur_id  <= '0;
      k       <= '0;
      op_lat  <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      res     <= '0;
      y       <= '0;
      done_id <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            cur_id <= sel_id;
            op_lat <= op_flat[2*sel_id +: 2];
            a_lat  <= a_flat[WIDTH*sel_id +: WIDTH];
            b_lat  <= b_flat[WIDTH*sel_id +: WIDTH];
            k      <= '0;
          end
        end
        S_EVAL: begin
          res <= res_nxt;
          k   <= k + 1'b1;
          // y and done_id change only here so they hold until the next result
          if (k_last) begin
            y       <= res_nxt;
            done_id <= cur_id;
          end
        end
        S_DONE: begin
          rr_ptr <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MUX_GATE_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                                    op_count <= '0;
    else if (state == S_DONE && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// tb/tb_mux_gate_sequencer.sv - scoreboard bench for mux_gate_sequencer
// Builds with or without MUX_GATE_SEQ_STATS_EN.
module tb_mux_gate_sequencer;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [2*N-1:0]   op_flat;
  logic [N*W-1:0]   a_flat;
  logic [N*W-1:0]   b_flat;
  logic [N-1:0]     grant;
  logic             busy;
  logic             done;
  logic [1:0]       done_id;
  logic [W-1:0]     y;
`ifdef MUX_GATE_SEQ_STATS_EN
  logic [15:0]      op_count;
`endif

  mux_gate_sequencer #(.N_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op_flat (op_flat),
    .a_flat  (a_flat),
    .b_flat  (b_flat),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .y       (y)
`ifdef MUX_GATE_SEQ_STATS_EN
    ,
    .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [W-1:0] y;
  } exp_t;

  exp_t sb[$];
  int   exp_grant[$];
  int   errors  = 0;
  int   checks  = 0;
  int   n_grant = 0;
  int   n_done  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (|grant) begin
        int g;
        check("grant_onehot", 32'($onehot(grant)), 1);
        check("grant_with_done", 32'(done), 0);
        if (exp_grant.size() == 0) check("unexpected_grant", 32'(grant), 0);
        else begin
          g = exp_grant.pop_front();
          check("grant_id", 32'(grant), 32'(1 << g));
        end
        n_grant++;
      end
      if (done) begin
        exp_t e;
        n_done++;
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("done_id", 32'(done_id), 32'(e.id));
          check("y", 32'(y), 32'(e.y));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_flat[2*id +: 2] = op;
    a_flat[W*id +: W]  = a;
    b_flat[W*id +: W]  = b;
  endtask

  task automatic expect_op(input int id, input logic [W-1:0] ey);
    exp_t e;
    e.id = id;
    e.y  = ey;
    sb.push_back(e);
    exp_grant.push_back(id);
  endtask

  // one op from an idle sequencer; operands are scrambled right after grant
  task automatic run_op(input int id, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ey);
    int n;
    int m;
    expect_op(id, ey);
    drive(id, op, a, b);
    req[id] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!grant[id] && n < 20);
    check("grant_latency", n, 1);
    req[id] = 1'b0;
    drive(id, 2'($urandom), W'($urandom), W'($urandom));
    m = 0;
    do begin
      tick();
      m++;
      if (m == 1) check("grant_pulse", 32'(grant), 0);
    end while (!done && m < W + 6);
    check("done_latency", m, W);
    tick();
  endtask

  task automatic wait_grants(input int target);
    int t;
    t = 0;
    while (n_grant < target && t < 400) begin tick(); t++; end
    check("grant_count", n_grant, target);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 400) begin tick(); t++; end
    check("drain", sb.size(), 0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    exp_grant.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int id;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst = 1'b1;
    req = '0;
    op_flat = '0;
    a_flat = '0;
    b_flat = '0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_done_id", 32'(done_id), 0);
    check("rst_y", 32'(y), 0);
    rst = 1'b0;
    tick();

    run_op(0, 2'b00, 8'hA5, 8'h0F, 8'hAF);

    run_op(2, 2'b00, 8'h33, 8'h55, 8'h77);
    run_op(2, 2'b01, 8'h33, 8'h55, 8'h11);
    run_op(2, 2'b10, 8'h33, 8'h55, 8'h66);
    run_op(2, 2'b11, 8'h33, 8'h55, 8'h99);

    for (int i = 0; i < 6; i++) begin
      id = $urandom_range(0, N - 1);
      op = 2'($urandom);
      a  = W'($urandom);
      b  = W'($urandom);
      run_op(id, op, a, b, model(op, a, b));
    end

    // all requesters held from reset: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) drive(i, 2'b10, W'(i * 17 + 3), 8'h5A);
    foreach (exp_grant[i]) ;
    expect_op(0, model(2'b10, 8'd3, 8'h5A));
    expect_op(1, model(2'b10, 8'd20, 8'h5A));
    expect_op(2, model(2'b10, 8'd37, 8'h5A));
    expect_op(3, model(2'b10, 8'd54, 8'h5A));
    expect_op(0, model(2'b10, 8'd3, 8'h5A));
    base = n_grant;
    req = '1;
    wait_grants(base + 5);
    req = '0;
    wait_idle();

    // after a grant to 1, requesters 0 and 3 alternate starting with 3
    do_reset();
    for (int i = 0; i < N; i++) drive(i, 2'b01, W'(8'hF0 | i), W'(8'h3C + i));
    expect_op(1, model(2'b01, 8'hF1, 8'h3D));
    expect_op(3, model(2'b01, 8'hF3, 8'h3F));
    expect_op(0, model(2'b01, 8'hF0, 8'h3C));
    expect_op(3, model(2'b01, 8'hF3, 8'h3F));
    expect_op(0, model(2'b01, 8'hF0, 8'h3C));
    base = n_grant;
    req = 4'b0010;
    wait_grants(base + 1);
    req = 4'b1001;
    wait_grants(base + 5);
    req = '0;
    wait_idle();

    // reset during the k=3 EVAL cycle discards the op
    exp_grant.push_back(2);
    drive(2, 2'b00, 8'hFF, 8'h00);
    req = 4'b0100;
    base = n_grant;
    wait_grants(base + 1);
    req = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_grant", 32'(grant), 0);
    rst = 1'b0;
    base = n_done;
    repeat (2 * W) tick();
    check("midrst_no_done", n_done, base);
    run_op(1, 2'b01, 8'hC3, 8'h5A, 8'h42);

`ifdef MUX_GATE_SEQ_STATS_EN
    do_reset();
    check("stats_rst", 32'(op_count), 0);
    run_op(0, 2'b00, 8'h01, 8'h02, 8'h03);
    run_op(1, 2'b10, 8'hFF, 8'h0F, 8'hF0);
    run_op(3, 2'b11, 8'h00, 8'h00, 8'hFF);
    check("stats_three", 32'(op_count), 3);
    do_reset();
    check("stats_clear", 32'(op_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
